// File: rtl/stage_pkg.sv
// Shared types and stage numbering for the multi-cycle instruction sequencer.
package stage_pkg;

    typedef enum logic [1:0] {INIT, RUN, WAIT_STEP, HALTED} seq_state_t;

    // Default 9-stage map: data-path stages interleaved with their latch stages.
    localparam int unsigned STG_IF     = 0;
    localparam int unsigned STG_IF_ID  = 1;
    localparam int unsigned STG_ID     = 2;
    localparam int unsigned STG_ID_EX  = 3;
    localparam int unsigned STG_EX     = 4;
    localparam int unsigned STG_EX_MEM = 5;
    localparam int unsigned STG_MEM    = 6;
    localparam int unsigned STG_MEM_WB = 7;
    localparam int unsigned STG_WB_IF  = 8;

    localparam int unsigned N_STAGES_DEFAULT   = STG_WB_IF + 1;
    localparam logic [8:0]  DEFAULT_STALL_MASK = 9'(1) << STG_MEM;

endpackage

// File: rtl/retire_counter.sv
// Free-running wrap-around event counter with synchronous clear and count enable.
module retire_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: one-cycle init, then a ring of stage strobes with
// stall hold, single-step gating, halt at instruction boundary and a retire counter.
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int unsigned          N_STAGES   = N_STAGES_DEFAULT,
    parameter logic [N_STAGES-1:0]  STALL_MASK = N_STAGES'(DEFAULT_STALL_MASK),
    parameter int unsigned          CNT_W      = 32,
    localparam int unsigned         IDX_W      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                halt_req,
    input  logic                step_mode,
    input  logic                step,
    output logic [N_STAGES-1:0] stage_en,
    output logic [IDX_W-1:0]    stage_idx,
    output logic                stage_reset_n,
    output logic                instr_done,
    output logic                halted,
    output logic [CNT_W-1:0]    instr_count
);

    localparam logic [IDX_W-1:0] FIRST = IDX_W'(STG_IF);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_STAGES - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] stage_q, stage_d;
    logic             held;
    logic             cnt_en;

    assign held = stall && STALL_MASK[stage_q];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= INIT;
            stage_q <= FIRST;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end

    // Strobes are masked by reset_n so a mid-instruction reset never writes state.
    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        stage_en      = '0;
        stage_idx     = '0;
        instr_done    = 1'b0;
        halted        = 1'b0;
        stage_reset_n = 1'b1;
        cnt_en        = 1'b0;
        case (state_q)
            INIT: begin
                stage_reset_n = 1'b0;
                state_d       = RUN;
                stage_d       = FIRST;
            end
            RUN: begin
                stage_idx = stage_q;
                if (!held) begin
                    if (stage_q == FIRST && step_mode && !step) begin
                        state_d = WAIT_STEP;
                    end else begin
                        stage_en[stage_q] = reset_n;
                        if (stage_q == LAST) begin
                            instr_done = reset_n;
                            cnt_en     = 1'b1;
                            stage_d    = FIRST;
                            if (halt_req) begin
                                state_d = HALTED;
                            end
                        end else begin
                            stage_d = stage_q + IDX_W'(1);
                        end
                    end
                end
            end
            WAIT_STEP: begin
                // Leaving step mode while parked resumes at stage 0 on the next cycle.
                if (!step_mode) begin
                    state_d = RUN;
                end else if (step && !held) begin
                    stage_en[FIRST] = reset_n;
                    stage_d         = FIRST + IDX_W'(1);
                    state_d         = RUN;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk  (clk),
        .clear(!reset_n),
        .en   (cnt_en),
        .count(instr_count)
    );

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: stimulus queues expected strobes, monitor checks them.
module tb_stage_sequencer;

    localparam int NS = 9;
    localparam int CW = 4;
    localparam logic [NS-1:0] MASK = 9'b1_0100_0000;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          stall     = 1'b0;
    logic          halt_req  = 1'b0;
    logic          step_mode = 1'b0;
    logic          step      = 1'b0;
    logic [NS-1:0] stage_en;
    logic [3:0]    stage_idx;
    logic          stage_reset_n;
    logic          instr_done;
    logic          halted;
    logic [CW-1:0] instr_count;

    int n_cmp     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int exp_count = 0;
    bit mon_en    = 1'b0;

    typedef struct {
        int cyc;
        int stage;
        bit done;
        int count;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    stage_sequencer #(
        .N_STAGES  (NS),
        .STALL_MASK(MASK),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .halt_req     (halt_req),
        .step_mode    (step_mode),
        .step         (step),
        .stage_en     (stage_en),
        .stage_idx    (stage_idx),
        .stage_reset_n(stage_reset_n),
        .instr_done   (instr_done),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction from its stage-0 cycle and queues the strobes it must produce.
    task automatic run_instr(input int stall_at, input int stall_len, input bit step0,
                             input int step_mid, input int halt_at, input int mode_off_at,
                             input int rst_at);
        int s       = 0;
        int left    = 0;
        bit started = 1'b0;
        exp_t e;
        while (s < NS) begin
            if (s == rst_at) begin
                reset_n   = 1'b0;
                exp_count = 0;
                stall     = 1'b0;
                step      = 1'b0;
                return;
            end
            if (s == halt_at) halt_req = 1'b1;
            if (s == mode_off_at) step_mode = 1'b0;
            if (s == stall_at && !started) begin
                left    = stall_len;
                started = 1'b1;
            end
            stall = (left > 0);
            if (left > 0) left--;
            step = (step0 && s == 0) || (s == step_mid);
            if (stall && MASK[s]) begin
                tick();
            end else begin
                e.cyc   = cyc;
                e.stage = s;
                e.done  = (s == NS - 1);
                e.count = exp_count & ((1 << CW) - 1);
                exp_q.push_back(e);
                if (s == NS - 1) exp_count++;
                s++;
                tick();
            end
        end
        stall = 1'b0;
        step  = 1'b0;
    endtask

    task automatic check_idle(input int n, input bit halted_exp);
        repeat (n) begin
            @(negedge clk);
            check("idle_stage_en", 32'(stage_en), 32'd0);
            check("idle_stage_idx", 32'(stage_idx), 32'd0);
            check("idle_halted", 32'(halted), 32'(halted_exp));
            check("idle_count", 32'(instr_count), 32'(exp_count & ((1 << CW) - 1)));
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (stage_en !== '0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got stage_en=%0h, expected none (cycle %0d)",
                             stage_en, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("stage_en", 32'(stage_en), 32'(NS'(1) << mon_e.stage));
                    check("stage_idx", 32'(stage_idx), 32'(mon_e.stage));
                    check("instr_done", 32'(instr_done), 32'(mon_e.done));
                    check("strobe_count", 32'(instr_count), 32'(mon_e.count));
                end
            end else if (instr_done !== 1'b0) begin
                check("done_without_strobe", 32'(instr_done), 32'd0);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not complete, expected finish before 50000 ns");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        tick();
        mon_en = 1'b1;
        check("rst_stage_reset_n", 32'(stage_reset_n), 32'd0);
        check("rst_stage_en", 32'(stage_en), 32'd0);
        check("rst_instr_done", 32'(instr_done), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_stage_idx", 32'(stage_idx), 32'd0);
        reset_n = 1'b1;
        tick();

        repeat (3) run_instr(-1, 0, 1'b0, -1, -1, -1, -1);
        check("count_after_3", 32'(instr_count), 32'd3);
        check("run_stage_reset_n", 32'(stage_reset_n), 32'd1);

        run_instr(6, 4, 1'b0, -1, -1, -1, -1);
        run_instr(2, 4, 1'b0, -1, -1, -1, -1);

        step_mode = 1'b1;
        check_idle(3, 1'b0);
        run_instr(-1, 0, 1'b1, -1, -1, -1, -1);
        check_idle(3, 1'b0);
        run_instr(-1, 0, 1'b1, 4, -1, -1, -1);
        check_idle(2, 1'b0);
        run_instr(-1, 0, 1'b1, -1, -1, 2, -1);

        run_instr(-1, 0, 1'b0, -1, -1, -1, 5);
        tick();
        check("midrst_stage_reset_n", 32'(stage_reset_n), 32'd0);
        check("midrst_count", 32'(instr_count), 32'd0);
        reset_n = 1'b1;
        tick();

        repeat (16) run_instr(-1, 0, 1'b0, -1, -1, -1, -1);
        check("count_wrap", 32'(instr_count), 32'd0);
        check("pre_halt_halted", 32'(halted), 32'd0);

        run_instr(8, 2, 1'b0, -1, 3, -1, -1);
        halt_req  = 1'b0;
        step_mode = 1'b1;
        step      = 1'b1;
        check_idle(1, 1'b1);
        step = 1'b0;
        check_idle(4, 1'b1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
